// File: rtl/butterfly_mem_arbiter_pkg.sv
// rtl/butterfly_mem_arbiter_pkg.sv - shared types and grant encodings for the Butterfly memory arbiter
package butterfly_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } arb_state_t;

  localparam logic [3:0] GNT_NONE = 4'hF;

  // The video fetcher is always the grant index just past the last CPU.
  function automatic logic [3:0] gnt_vid(input int nreq);
    return 4'(nreq);
  endfunction

endpackage

// File: rtl/butterfly_mem_arbiter_if.sv
// rtl/butterfly_mem_arbiter_if.sv - CPU, video and memory-side signals of the shared memory port
interface butterfly_mem_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 16,
  parameter int DW   = 16
);
  logic [NREQ-1:0]    req_cyc;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_adr;
  logic [NREQ*DW-1:0] req_dat;
  logic [NREQ-1:0]    req_ack;
  logic [NREQ-1:0]    req_err;
  logic [DW-1:0]      rd_dat;
  logic               vid_cyc;
  logic               vid_urgent;
  logic [AW-1:0]      vid_adr;
  logic               vid_ack;
  logic               m_cyc;
  logic               m_we;
  logic [AW-1:0]      m_adr;
  logic [DW-1:0]      m_dat_o;
  logic [DW-1:0]      m_dat_i;
  logic               m_ack;
  logic [3:0]         gnt_idx;

  modport slave (
    input  req_cyc, req_we, req_adr, req_dat, vid_cyc, vid_urgent, vid_adr, m_dat_i, m_ack,
    output req_ack, req_err, rd_dat, vid_ack, m_cyc, m_we, m_adr, m_dat_o, gnt_idx
  );

  modport master (
    output req_cyc, req_we, req_adr, req_dat, vid_cyc, vid_urgent, vid_adr, m_dat_i, m_ack,
    input  req_ack, req_err, rd_dat, vid_ack, m_cyc, m_we, m_adr, m_dat_o, gnt_idx
  );
endinterface

// File: rtl/butterfly_mem_arbiter_rr_pick.sv
// rtl/butterfly_mem_arbiter_rr_pick.sv - combinational round-robin picker, search starts at ptr+1
module butterfly_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [2:0]      i_ptr,
  output logic            o_valid,
  output logic [2:0]      o_idx
);
  int w_best;
  int w_dist;

  // Lowest circular distance from the last served CPU wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_best  = NREQ;
    w_dist  = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i - int'(i_ptr) - 1 + 2 * NREQ) % NREQ;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_valid = 1'b1;
        o_idx   = 3'(i);
      end
    end
  end
endmodule

// File: rtl/butterfly_mem_arbiter.sv
// rtl/butterfly_mem_arbiter.sv - arbiter for the shared memory port: CPU round-robin, urgent video first
// Optional bus-error timeout enabled by defining BUTTERFLY_ARB_TIMEOUT_EN.
module butterfly_mem_arbiter
  import butterfly_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input logic                    clk,
  input logic                    rst,
  butterfly_mem_arbiter_if.slave bus
);
  localparam logic [3:0] GNT_VID = gnt_vid(NREQ);

  arb_state_t    r_state, w_next_state;
  logic [3:0]    r_owner, w_next_owner;
  logic [2:0]    r_ptr, w_next_ptr;
  logic          w_pick_valid;
  logic [2:0]    w_pick_idx;
  logic          w_owner_cyc;
  logic          w_owner_we;
  logic [AW-1:0] w_owner_adr;
  logic [DW-1:0] w_owner_dat;
  logic          w_ack;
  logic          w_err;
  logic          w_release;

  butterfly_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req   (bus.req_cyc),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_owner_cyc = 1'b0;
    w_owner_we  = 1'b0;
    w_owner_adr = '0;
    w_owner_dat = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == 4'(i)) begin
        w_owner_cyc = bus.req_cyc[i];
        w_owner_we  = bus.req_we[i];
        w_owner_adr = bus.req_adr[i*AW +: AW];
        w_owner_dat = bus.req_dat[i*DW +: DW];
      end
    end
    // Video is read-only, so its write enable stays low.
    if (r_owner == GNT_VID) begin
      w_owner_cyc = bus.vid_cyc;
      w_owner_adr = bus.vid_adr;
    end
  end

`ifdef BUTTERFLY_ARB_TIMEOUT_EN
  logic [7:0] r_tmo;
  logic       w_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo <= '0;
    end else if ((r_state == IDLE) || ((r_state == BUSY) && bus.m_ack)) begin
      r_tmo <= '0;
    end else if (r_state == BUSY) begin
      r_tmo <= r_tmo + 8'd1;
    end
  end

  assign w_timeout = (r_state == BUSY) && (r_tmo == 8'(TIMEOUT));
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_owner = r_owner;
    w_next_ptr   = r_ptr;
    w_ack        = 1'b0;
    w_err        = 1'b0;
    w_release    = 1'b0;
    bus.m_cyc    = 1'b0;
    bus.m_we     = 1'b0;
    bus.m_adr    = '0;
    bus.m_dat_o  = '0;
    bus.req_ack  = '0;
    bus.req_err  = '0;
    bus.vid_ack  = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.vid_cyc && bus.vid_urgent) begin
          w_next_state = BUSY;
          w_next_owner = GNT_VID;
        end else if (w_pick_valid) begin
          w_next_state = BUSY;
          w_next_owner = {1'b0, w_pick_idx};
        end else if (bus.vid_cyc) begin
          w_next_state = BUSY;
          w_next_owner = GNT_VID;
        end
      end
      BUSY: begin
`ifdef BUTTERFLY_ARB_TIMEOUT_EN
        if (w_timeout) begin
          w_err = w_owner_cyc;
          if (w_owner_cyc) w_next_state = ERR;
          else w_release = 1'b1;
        end else
`endif
        begin
          bus.m_cyc   = w_owner_cyc;
          bus.m_we    = w_owner_we;
          bus.m_adr   = w_owner_adr;
          bus.m_dat_o = w_owner_dat;
          w_ack       = bus.m_ack & w_owner_cyc;
          w_release   = !w_owner_cyc;
        end
      end
`ifdef BUTTERFLY_ARB_TIMEOUT_EN
      ERR: begin
        w_err     = w_owner_cyc;
        w_release = !w_owner_cyc;
      end
`endif
      default: begin
        w_next_state = IDLE;
        w_next_owner = GNT_NONE;
      end
    endcase

    // Pointer only advances on CPU ownership so video never skews the CPU rotation.
    if (w_release) begin
      w_next_state = IDLE;
      w_next_owner = GNT_NONE;
      if (r_owner != GNT_VID) w_next_ptr = r_owner[2:0];
    end

    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == 4'(i)) begin
        bus.req_ack[i] = w_ack;
        bus.req_err[i] = w_err;
      end
    end
    bus.vid_ack = w_ack && (r_owner == GNT_VID);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= GNT_NONE;
      r_ptr   <= 3'(NREQ - 1);
    end else begin
      r_state <= w_next_state;
      r_owner <= w_next_owner;
      r_ptr   <= w_next_ptr;
    end
  end

  assign bus.gnt_idx = r_owner;
  assign bus.rd_dat  = bus.m_dat_i;
endmodule

// File: tb/tb_butterfly_mem_arbiter.sv
// tb/tb_butterfly_mem_arbiter.sv - self-checking bench: vector table, corner sequences, random vs model
module tb_butterfly_mem_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  butterfly_mem_arbiter_if #(.NREQ(N), .AW(16), .DW(16)) bus_if ();

  butterfly_mem_arbiter #(.NREQ(N), .AW(16), .DW(16), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] cyc;
    logic       vc;
    logic       vu;
    logic       ack;
    logic [3:0] gnt;
    logic       mcyc;
    logic [3:0] rack;
    logic       vack;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.req_cyc    = '0;
    bus_if.req_we     = '0;
    bus_if.req_adr    = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    bus_if.req_dat    = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    bus_if.vid_cyc    = 1'b0;
    bus_if.vid_urgent = 1'b0;
    bus_if.vid_adr    = 16'h8000;
    bus_if.m_dat_i    = '0;
    bus_if.m_ack      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference model state: owner -1 none, 0..N-1 CPU, N video; ptr = last CPU served.
  int         m_own;
  int         m_ptr;
  logic       m_ocyc;
  logic [3:0] e_rack;
  logic       e_vack;
  bit         found;
  int         pulses;
  logic       seen;
  logic [3:0] mask;

  task automatic model_check();
    m_ocyc = 1'b0;
    if (m_own == N) m_ocyc = bus_if.vid_cyc;
    else if (m_own >= 0) m_ocyc = bus_if.req_cyc[m_own];
    e_rack = '0;
    e_vack = 1'b0;
    if (m_ocyc && bus_if.m_ack) begin
      if (m_own == N) e_vack = 1'b1;
      else e_rack[m_own] = 1'b1;
    end
    chk("rnd_gnt", bus_if.gnt_idx, (m_own < 0) ? 4'hF : 4'(m_own));
    chk("rnd_mcyc", bus_if.m_cyc, m_ocyc);
    chk("rnd_rack", bus_if.req_ack, e_rack);
    chk("rnd_vack", bus_if.vid_ack, e_vack);
    chk("rnd_err", bus_if.req_err, 4'h0);
    chk("rnd_rddat", bus_if.rd_dat, bus_if.m_dat_i);
    if (m_ocyc) begin
      if (m_own == N) begin
        chk("rnd_we", bus_if.m_we, 1'b0);
        chk("rnd_adr", bus_if.m_adr, bus_if.vid_adr);
      end else begin
        chk("rnd_we", bus_if.m_we, bus_if.req_we[m_own]);
        chk("rnd_adr", bus_if.m_adr, bus_if.req_adr[m_own*16 +: 16]);
        chk("rnd_dato", bus_if.m_dat_o, bus_if.req_dat[m_own*16 +: 16]);
      end
    end
  endtask

  task automatic model_step();
    if (m_own < 0) begin
      if (bus_if.vid_cyc && bus_if.vid_urgent) begin
        m_own = N;
      end else begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && bus_if.req_cyc[(m_ptr + k) % N]) begin
            m_own = (m_ptr + k) % N;
            found = 1;
          end
        end
        if (!found && bus_if.vid_cyc) m_own = N;
      end
    end else if (!m_ocyc) begin
      if (m_own < N) m_ptr = m_own;
      m_own = -1;
    end
  endtask

  initial begin
    tbl[0]  = '{4'b0101, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0101, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 4'b0001, 1'b0};
    tbl[2]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0};
    tbl[3]  = '{4'b0101, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0, 4'b0000, 1'b0};
    tbl[4]  = '{4'b0101, 1'b0, 1'b0, 1'b1, 4'h2, 1'b1, 4'b0100, 1'b0};
    tbl[5]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'h2, 1'b0, 4'b0000, 1'b0};
    tbl[6]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 4'b0000, 1'b0};
    tbl[7]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'b0000, 1'b0};
    tbl[8]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0};
    tbl[9]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 4'b0000, 1'b0};
    tbl[10] = '{4'b1000, 1'b1, 1'b0, 1'b0, 4'hF, 1'b0, 4'b0000, 1'b0};
    tbl[11] = '{4'b1000, 1'b1, 1'b0, 1'b1, 4'h3, 1'b1, 4'b1000, 1'b0};
    tbl[12] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 4'b0000, 1'b0};
    tbl[13] = '{4'b0000, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 4'b0000, 1'b0};
    tbl[14] = '{4'b0000, 1'b1, 1'b0, 1'b1, 4'h4, 1'b1, 4'b0000, 1'b1};
    tbl[15] = '{4'b1000, 1'b0, 1'b0, 1'b0, 4'h4, 1'b0, 4'b0000, 1'b0};
    tbl[16] = '{4'b1000, 1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 4'b0000, 1'b0};
    tbl[17] = '{4'b1000, 1'b1, 1'b1, 1'b1, 4'h4, 1'b1, 4'b0000, 1'b1};
    tbl[18] = '{4'b1000, 1'b0, 1'b0, 1'b0, 4'h4, 1'b0, 4'b0000, 1'b0};
    tbl[19] = '{4'b1000, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 4'b0000, 1'b0};
    tbl[20] = '{4'b1000, 1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 4'b1000, 1'b0};
    tbl[21] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0, 4'b0000, 1'b0};
    tbl[22] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0, 4'b0000, 1'b0};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_gnt", bus_if.gnt_idx, 4'hF);
    chk("rst_mcyc", bus_if.m_cyc, 1'b0);
    chk("rst_mwe", bus_if.m_we, 1'b0);
    chk("rst_adr", bus_if.m_adr, 16'h0);
    chk("rst_dato", bus_if.m_dat_o, 16'h0);
    chk("rst_acks", {bus_if.req_ack, bus_if.vid_ack}, 5'h0);
    chk("rst_err", bus_if.req_err, 4'h0);
    tick();

    // Vector table: rotation 0,2,0, CPU vs non-urgent/urgent video, ack gating
    do_reset();
    for (int v = 0; v < 23; v++) begin
      bus_if.req_cyc    = tbl[v].cyc;
      bus_if.vid_cyc    = tbl[v].vc;
      bus_if.vid_urgent = tbl[v].vu;
      bus_if.m_ack      = tbl[v].ack;
      @(negedge clk);
      chk($sformatf("vec%0d_gnt", v), bus_if.gnt_idx, tbl[v].gnt);
      chk($sformatf("vec%0d_mcyc", v), bus_if.m_cyc, tbl[v].mcyc);
      chk($sformatf("vec%0d_rack", v), bus_if.req_ack, tbl[v].rack);
      chk($sformatf("vec%0d_vack", v), bus_if.vid_ack, tbl[v].vack);
      tick();
    end

    // CPU1 burst of 4 acks while urgent video waits
    do_reset();
    bus_if.req_cyc = 4'b0010;
    tick();
    bus_if.vid_cyc    = 1'b1;
    bus_if.vid_urgent = 1'b1;
    bus_if.m_ack      = 1'b1;
    pulses = 0;
    seen   = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus_if.req_ack[1] && bus_if.gnt_idx == 4'h1) pulses++;
      seen = seen | bus_if.vid_ack;
      tick();
    end
    chk("burst_pulses", pulses, 4);
    chk("burst_no_vack", seen, 1'b0);
    bus_if.req_cyc = 4'b0000;
    bus_if.m_ack   = 1'b0;
    @(negedge clk);
    chk("burst_drop_mcyc", bus_if.m_cyc, 1'b0);
    tick();
    @(negedge clk);
    chk("burst_turnaround", bus_if.gnt_idx, 4'hF);
    tick();
    @(negedge clk);
    chk("burst_vid_gnt", bus_if.gnt_idx, 4'h4);
    tick();

    // Video grant cannot write; read data broadcast
    do_reset();
    bus_if.req_we  = 4'hF;
    bus_if.vid_cyc = 1'b1;
    bus_if.m_dat_i = 16'hBEEF;
    bus_if.m_ack   = 1'b1;
    found = 0;
    for (int c = 0; c < 5 && !found; c++) begin
      @(negedge clk);
      if (bus_if.gnt_idx == 4'h4) found = 1;
      else tick();
    end
    chk("vid_granted", found, 1'b1);
    chk("vid_mwe", bus_if.m_we, 1'b0);
    chk("vid_mcyc", bus_if.m_cyc, 1'b1);
    chk("vid_adr", bus_if.m_adr, 16'h8000);
    chk("vid_rddat", bus_if.rd_dat, 16'hBEEF);
    chk("vid_ack", bus_if.vid_ack, 1'b1);
    tick();

    // Reset mid-burst of CPU2
    do_reset();
    bus_if.req_cyc = 4'b0100;
    tick();
    @(negedge clk);
    chk("rstmid_gnt2", bus_if.gnt_idx, 4'h2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_if.req_cyc = 4'b0101;
    @(negedge clk);
    chk("rstmid_mcyc", bus_if.m_cyc, 1'b0);
    chk("rstmid_gnt", bus_if.gnt_idx, 4'hF);
    tick();
    @(negedge clk);
    chk("rstmid_cpu0", bus_if.gnt_idx, 4'h0);
    tick();

    // Stalled slave: bus error after TIMEOUT only when enabled
    do_reset();
    bus_if.req_cyc = 4'b0001;
    tick();
    seen = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
`ifdef BUTTERFLY_ARB_TIMEOUT_EN
      if (c < 9) seen = seen | bus_if.req_err[0] | !bus_if.m_cyc;
      if (c == 9) begin
        chk("tmo_err", bus_if.req_err, 4'b0001);
        chk("tmo_mcyc", bus_if.m_cyc, 1'b0);
      end
`else
      seen = seen | bus_if.req_err[0] | !bus_if.m_cyc;
`endif
      tick();
    end
    chk("tmo_quiet", seen, 1'b0);
    bus_if.req_cyc = 4'b0000;
    tick();
    tick();

    // Randomized traffic against the reference model
    do_reset();
    m_own = -1;
    m_ptr = N - 1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      mask = '0;
      for (int b = 0; b < N; b++) mask[b] = ($urandom_range(3) == 0);
      bus_if.req_cyc ^= mask;
      if ($urandom_range(3) == 0) bus_if.vid_cyc = !bus_if.vid_cyc;
      bus_if.vid_urgent = ($urandom_range(3) == 0);
      bus_if.req_we     = 4'($urandom);
      bus_if.req_adr    = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      bus_if.req_dat    = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      bus_if.vid_adr    = 16'($urandom);
      bus_if.m_dat_i    = 16'($urandom);
      bus_if.m_ack      = ($urandom_range(1) == 1);
      @(negedge clk);
      model_check();
      model_step();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
